linebuf_scheduler: RTL and testbench

Sequencer for the scan-doubling line buffer in front of the VGA driver. It shares one single-port 512×15 line RAM between the PPU pixel writer and the VGA scan reader on fixed time slots, ping-pongs two 256-pixel banks per PPU line, and pulses the driver's `sync` input to lock the VGA frame to the PPU frame. It sits between the PPU output and `VgaDriver`, and drives the driver's `pixel` input.

---
 rtl/linebuf_scheduler.sv | 91 +++++++++
 tb/tb_linebuf_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_scheduler.sv
// linebuf_scheduler: time-slots one single-port line RAM between PPU pixel writes and VGA scan reads,
// ping-pongs two 256-pixel banks per PPU line and pulses vga_sync to lock the VGA frame to the PPU frame.
module linebuf_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter bit RESYNC_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ppu_frame_start,
    input  logic        ppu_line_start,
    input  logic        ppu_pixel_valid,
    input  logic [14:0] ppu_pixel,
    input  logic [9:0]  vga_next_x,
    input  logic [9:0]  vga_vcounter,
    output logic        vga_sync,
    output logic [14:0] vga_pixel,
    output logic [8:0]  mem_addr,
    output logic        mem_we,
    output logic [14:0] mem_wdata,
    input  logic [14:0] mem_rdata,
    output logic        overflow,
    output logic [7:0]  resync_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, PULSE, RUN} state_t;
    state_t state, state_nx;
    logic [23:0] fifo [FIFO_DEPTH];
    logic [23:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [8:0] wr_x, cur_x, last_addr;
    logic [14:0] hold;
    logic wr_bank, rd_bank, cur_bank, rdv;
    logic wr_slot, full, pop, take, push, drop;
    logic unused;
    assign unused = vga_next_x[9];
    assign wr_slot = vga_next_x[0];
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign pop = wr_slot && count != '0;
    // A line start takes effect for a pixel arriving in the same cycle.
    assign cur_bank = ppu_line_start ? ~wr_bank : wr_bank;
    assign cur_x = ppu_line_start ? 9'd0 : wr_x;
    assign take = ppu_pixel_valid && !cur_x[8];
    assign push = take && (!full || pop);
    assign drop = take && full && !pop;
    assign head = fifo[rd_ptr];
    assign mem_we = pop;
    assign mem_wdata = pop ? head[14:0] : '0;
    assign mem_addr = !rst_n ? '0 : !wr_slot ? {rd_bank, vga_next_x[8:1]} : pop ? head[23:15] : last_addr;
    assign vga_pixel = rdv ? mem_rdata : hold;
    assign vga_sync = state == PULSE;
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= {cur_bank, cur_x[7:0], ppu_pixel};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wr_x <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            overflow <= 1'b0;
            last_addr <= '0;
            rdv <= 1'b0;
            hold <= '0;
            state <= IDLE;
            resync_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (ppu_line_start) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
            wr_x <= cur_x + 9'(take);
            if (drop) overflow <= 1'b1;
            last_addr <= mem_addr;
            rdv <= !wr_slot;
            if (rdv) hold <= mem_rdata;
            state <= state_nx;
            if (state == PULSE && resync_count != 8'hFF) resync_count <= resync_count + 8'd1;
        end
    end
    // A frame start during the driver's vblank is treated as already locked.
    always_comb begin
        state_nx = state;
        if (state == PULSE) state_nx = RUN;
        else if (ppu_frame_start && (state == IDLE || (RESYNC_EN && vga_vcounter < 10'd480))) state_nx = PULSE;
    end
endmodule

// File: tb/tb_linebuf_scheduler.sv
// tb_linebuf_scheduler: scoreboarded checks of slotting, bank ping-pong, overflow and sync locking.
module tb_linebuf_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ppu_frame_start = 1'b0, ppu_line_start = 1'b0, ppu_pixel_valid = 1'b0;
    logic [14:0] ppu_pixel = '0;
    logic [9:0] vga_next_x = '0, vga_vcounter = '0;
    logic vga_sync, mem_we, overflow;
    logic [14:0] vga_pixel, mem_wdata, mem_rdata;
    logic [8:0] mem_addr;
    logic [7:0] resync_count;
    logic [14:0] ram [512];
    logic [23:0] exp_q[$], obs_q[$];
    logic [14:0] pix_q[$];
    int checks = 0, failures = 0;

    linebuf_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ppu_frame_start(ppu_frame_start), .ppu_line_start(ppu_line_start),
        .ppu_pixel_valid(ppu_pixel_valid), .ppu_pixel(ppu_pixel), .vga_next_x(vga_next_x),
        .vga_vcounter(vga_vcounter), .vga_sync(vga_sync), .vga_pixel(vga_pixel), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .overflow(overflow),
        .resync_count(resync_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk)
        if (rst_n && mem_we) obs_q.push_back({mem_addr, mem_wdata});

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ppu_frame_start = 1'b0;
        ppu_line_start = 1'b0;
        ppu_pixel_valid = 1'b0;
        vga_next_x = '0;
        vga_vcounter = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        pix_q.delete();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        ppu_pixel_valid = 1'b1;
        ppu_pixel = 15'h1234;
        vga_next_x = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL reset_sync got=%0h exp=0", vga_sync); end
        checks++; if (vga_pixel !== 15'h0) begin failures++; $display("FAIL reset_pixel got=%h exp=0", vga_pixel); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", mem_we); end
        checks++; if (mem_addr !== 9'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 15'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        checks++; if (resync_count !== 8'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", resync_count); end
        ppu_pixel_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL idle_sync got=%0h exp=0", vga_sync); end
            next_cycle();
        end
    endtask

    task automatic test_write_readback();
        logic [23:0] e, o;
        logic [9:0] nx;
        do_reset();
        nx = '0;
        ppu_line_start = 1'b1;
        next_cycle();
        ppu_line_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ppu_pixel_valid = 1'b1;
            ppu_pixel = 15'(i);
            vga_next_x = nx;
            exp_q.push_back({1'b1, 8'(i), 15'(i)});
            next_cycle();
            ppu_pixel_valid = 1'b0;
            nx = nx + 10'd1;
            vga_next_x = nx;
            next_cycle();
            nx = nx + 10'd1;
        end
        for (int i = 0; i < 4; i++) begin
            vga_next_x = 10'(i);
            next_cycle();
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL wb_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wb_write got=%h exp=%h", o, e); end
        end
        ppu_line_start = 1'b1;
        vga_next_x = 10'd1;
        next_cycle();
        ppu_line_start = 1'b0;
        for (int k = 0; k <= 512; k++) begin
            vga_next_x = k < 512 ? 10'(k) : 10'd1;
            if (k < 512 && k % 2 == 0) begin
                pix_q.push_back(15'(k / 2));
                pix_q.push_back(15'(k / 2));
            end
            @(negedge clk);
            if (k >= 1) begin
                e[14:0] = pix_q.pop_front();
                checks++; if (vga_pixel !== e[14:0]) begin failures++; $display("FAIL readback k=%0d got=%h exp=%h", k, vga_pixel, e[14:0]); end
            end
            next_cycle();
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wb_overflow got=%0h exp=0", overflow); end
    endtask

    task automatic test_burst_overflow();
        logic [23:0] e, o;
        do_reset();
        ppu_line_start = 1'b1;
        next_cycle();
        ppu_line_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ppu_pixel_valid = 1'b1;
            ppu_pixel = 15'(16'h100 + i);
            vga_next_x = (i == 1 || i == 2) ? 10'd1 : 10'd0;
            if (i < 6) exp_q.push_back({1'b1, 8'(i), 15'(16'h100 + i)});
            next_cycle();
        end
        ppu_pixel_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vga_next_x = 10'(i);
            next_cycle();
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL burst_write got=%h exp=%h", o, e); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow got=%0h exp=1", overflow); end
    endtask

    task automatic test_sync_lock();
        do_reset();
        ppu_frame_start = 1'b1;
        vga_vcounter = 10'd100;
        @(negedge clk);
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL sync_early got=%0h exp=0", vga_sync); end
        next_cycle();
        ppu_frame_start = 1'b0;
        @(negedge clk);
        checks++; if (vga_sync !== 1'b1) begin failures++; $display("FAIL sync_pulse got=%0h exp=1", vga_sync); end
        next_cycle();
        @(negedge clk);
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL sync_width got=%0h exp=0", vga_sync); end
        checks++; if (resync_count !== 8'd1) begin failures++; $display("FAIL sync_count1 got=%0d exp=1", resync_count); end
        next_cycle();
        ppu_frame_start = 1'b1;
        vga_vcounter = 10'd500;
        next_cycle();
        ppu_frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL sync_locked got=%0h exp=0", vga_sync); end
            next_cycle();
        end
        checks++; if (resync_count !== 8'd1) begin failures++; $display("FAIL sync_count_locked got=%0d exp=1", resync_count); end
        ppu_frame_start = 1'b1;
        vga_vcounter = 10'd100;
        next_cycle();
        @(negedge clk);
        checks++; if (vga_sync !== 1'b1) begin failures++; $display("FAIL resync_pulse got=%0h exp=1", vga_sync); end
        next_cycle();
        ppu_frame_start = 1'b0;
        @(negedge clk);
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL pulse_ignore got=%0h exp=0", vga_sync); end
        next_cycle();
        @(negedge clk);
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL pulse_ignore2 got=%0h exp=0", vga_sync); end
        checks++; if (resync_count !== 8'd2) begin failures++; $display("FAIL sync_count2 got=%0d exp=2", resync_count); end
        next_cycle();
        ppu_frame_start = 1'b1;
        next_cycle();
        ppu_frame_start = 1'b0;
        @(negedge clk);
        checks++; if (vga_sync !== 1'b1) begin failures++; $display("FAIL sync_pulse3 got=%0h exp=1", vga_sync); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL sync_reset got=%0h exp=0", vga_sync); end
        checks++; if (resync_count !== 8'd0) begin failures++; $display("FAIL sync_reset_count got=%0d exp=0", resync_count); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_line_start_pixel();
        do_reset();
        ppu_line_start = 1'b1;
        ppu_pixel_valid = 1'b1;
        ppu_pixel = 15'h7FFF;
        vga_next_x = 10'd0;
        next_cycle();
        ppu_line_start = 1'b0;
        ppu_pixel_valid = 1'b0;
        vga_next_x = 10'd1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ls_we got=%0h exp=1", mem_we); end
        checks++; if (mem_addr !== 9'h100) begin failures++; $display("FAIL ls_addr got=%h exp=100", mem_addr); end
        checks++; if (mem_wdata !== 15'h7FFF) begin failures++; $display("FAIL ls_wdata got=%h exp=7fff", mem_wdata); end
        next_cycle();
        vga_next_x = 10'h1FE;
        @(negedge clk);
        checks++; if (mem_addr !== 9'h0FF) begin failures++; $display("FAIL ls_rdbank got=%h exp=0ff", mem_addr); end
        next_cycle();
        vga_next_x = 10'h1FF;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL empty_we got=%0h exp=0", mem_we); end
        checks++; if (mem_addr !== 9'h0FF) begin failures++; $display("FAIL empty_hold got=%h exp=0ff", mem_addr); end
        next_cycle();
    endtask

    task automatic test_line_limit();
        logic [23:0] e, o;
        logic [9:0] nx;
        do_reset();
        nx = '0;
        ppu_line_start = 1'b1;
        next_cycle();
        ppu_line_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ppu_pixel_valid = 1'b1;
            ppu_pixel = 15'(i + 7);
            vga_next_x = nx;
            if (i < 256) exp_q.push_back({1'b1, 8'(i), 15'(i + 7)});
            next_cycle();
            ppu_pixel_valid = 1'b0;
            nx = nx + 10'd1;
            vga_next_x = nx;
            next_cycle();
            nx = nx + 10'd1;
        end
        for (int i = 0; i < 4; i++) begin
            vga_next_x = 10'(i);
            next_cycle();
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL limit_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL limit_write got=%h exp=%h", o, e); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL limit_overflow got=%0h exp=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_burst_overflow();
        test_sync_lock();
        test_line_start_pixel();
        test_line_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
